// File: rtl/reflet_pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous line in clk cycles.
// Optional glitch filter enabled by defining REFLET_PWM_CAPTURE_GLITCH_FILTER_EN.
module reflet_pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             stuck
);

  localparam logic [WIDTH-1:0] SAT  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == SAT) begin
      return SAT;
    end else begin
      return v + ONE;
    end
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  logic             line_d_r;
  logic             line_s;
  logic             rise_s;
  logic [WIDTH-1:0] pcnt_r;
  logic [WIDTH-1:0] hcnt_r;
  state_t           state_r;
  state_t           state_next_s;
  logic             pub_meas_s;
  logic             pub_timeout_s;
  logic [WIDTH-1:0] period_r;
  logic [WIDTH-1:0] high_time_r;
  logic             valid_r;
  logic             stuck_r;

`ifdef REFLET_PWM_CAPTURE_GLITCH_FILTER_EN
  logic s_d1_r;
  logic s_d2_r;

  // History of the synchronized line used by the filter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_d1_r <= 1'b0;
      s_d2_r <= 1'b0;
    end else begin
      s_d1_r <= sync2_r;
      s_d2_r <= s_d1_r;
    end
  end

  // Filtered line follows s only after three equal samples; line_d_r holds its previous value
  always_comb begin
    line_s = line_d_r;
    if ((sync2_r == s_d1_r) && (s_d1_r == s_d2_r)) begin
      line_s = sync2_r;
    end else begin
      line_s = line_d_r;
    end
  end
`else
  // Unfiltered: measure the synchronized line directly
  always_comb begin
    line_s = sync2_r;
  end
`endif

  // Synchronizer and edge-detect delay keep running regardless of enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      line_d_r <= 1'b0;
    end else begin
      sync1_r  <= in;
      sync2_r  <= sync1_r;
      line_d_r <= line_s;
    end
  end

  // Rising edge of the measured line
  always_comb begin
    rise_s = line_s & ~line_d_r;
  end

  // Period and high-time counters, saturating so a dead line cannot wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_r <= ZERO;
      hcnt_r <= ZERO;
    end else if (!enable) begin
      pcnt_r <= ZERO;
      hcnt_r <= ZERO;
    end else if (rise_s) begin
      pcnt_r <= ONE;
      hcnt_r <= ONE;
    end else begin
      pcnt_r <= sat_inc(pcnt_r);
      if (line_s) begin
        hcnt_r <= sat_inc(hcnt_r);
      end else begin
        hcnt_r <= hcnt_r;
      end
    end
  end

  // FSM state register; armed == MEASURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else if (!enable) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: an edge arms, a timeout disarms
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          state_next_s = MEASURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEASURE: begin
        if (!rise_s && (pcnt_r == SAT)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = MEASURE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: an edge beats a simultaneous timeout
  always_comb begin
    pub_meas_s    = 1'b0;
    pub_timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        pub_meas_s    = 1'b0;
        pub_timeout_s = 1'b0;
      end
      MEASURE: begin
        if (!enable) begin
          pub_meas_s    = 1'b0;
          pub_timeout_s = 1'b0;
        end else if (rise_s) begin
          pub_meas_s    = 1'b1;
        end else if (pcnt_r == SAT) begin
          pub_timeout_s = 1'b1;
        end else begin
          pub_meas_s    = 1'b0;
          pub_timeout_s = 1'b0;
        end
      end
      default: begin
        pub_meas_s    = 1'b0;
        pub_timeout_s = 1'b0;
      end
    endcase
  end

  // Published results; held between updates and while disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_r    <= ZERO;
      high_time_r <= ZERO;
      valid_r     <= 1'b0;
      stuck_r     <= 1'b0;
    end else begin
      valid_r <= pub_meas_s | pub_timeout_s;
      if (pub_meas_s) begin
        period_r    <= pcnt_r;
        high_time_r <= hcnt_r;
        stuck_r     <= 1'b0;
      end else if (pub_timeout_s) begin
        period_r    <= ZERO;
        high_time_r <= line_s ? SAT : ZERO;
        stuck_r     <= 1'b1;
      end else begin
        period_r    <= period_r;
        high_time_r <= high_time_r;
        stuck_r     <= stuck_r;
      end
    end
  end

  assign period    = period_r;
  assign high_time = high_time_r;
  assign valid     = valid_r;
  assign stuck     = stuck_r;

endmodule

// File: tb/tb_reflet_pwm_capture.sv
// Directed self-checking bench for reflet_pwm_capture (WIDTH=8).
module tb_reflet_pwm_capture;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stuck;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount = 0;
  int cyc = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  int vbase = 0;
  logic [7:0] last_period = 8'd0;
  logic [7:0] last_high = 8'd0;
  logic       last_stuck = 1'b0;

  reflet_pwm_capture #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in(in),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  // Record every published result on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid === 1'b1) begin
      vcount = vcount + 1;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      last_period = period;
      last_high = high_time;
      last_stuck = stuck;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      in = 1'b1;
      step(hi);
      in = 1'b0;
      step(lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; in = 1'b0;
    step(2);
    n_cmp++; if (period !== 8'd0) begin n_bad++; $display("FAIL reset_period got=%0d exp=0", period); end
    n_cmp++; if (high_time !== 8'd0) begin n_bad++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL reset_stuck got=%0b exp=0", stuck); end
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    vbase = vcount;
    pwm(3, 8, 1);
    n_cmp++; if (vcount !== vbase) begin n_bad++; $display("FAIL basic_first_edge valids=%0d exp=%0d", vcount - vbase, 0); end
    pwm(3, 8, 4);
    n_cmp++; if (vcount - vbase !== 4) begin n_bad++; $display("FAIL basic_count valids=%0d exp=4", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL basic_period got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd3) begin n_bad++; $display("FAIL basic_high got=%0d exp=3", last_high); end
    n_cmp++; if (last_stuck !== 1'b0) begin n_bad++; $display("FAIL basic_stuck got=%0b exp=0", last_stuck); end
  endtask

  task automatic test_pattern_change();
    pwm(9, 2, 3);
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL p92_period got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd9) begin n_bad++; $display("FAIL p92_high got=%0d exp=9", last_high); end
    pwm(1, 10, 3);
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL p110_period got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd1) begin n_bad++; $display("FAIL p110_high got=%0d exp=1", last_high); end
    n_cmp++; if (last_stuck !== 1'b0) begin n_bad++; $display("FAIL p110_stuck got=%0b exp=0", last_stuck); end
  endtask

  task automatic test_stuck_low();
    vbase = vcount;
    in = 1'b0;
    step(300);
    n_cmp++; if (vcount - vbase !== 1) begin n_bad++; $display("FAIL stuck0_count valids=%0d exp=1", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd0) begin n_bad++; $display("FAIL stuck0_period got=%0d exp=0", last_period); end
    n_cmp++; if (last_high !== 8'd0) begin n_bad++; $display("FAIL stuck0_high got=%0d exp=0", last_high); end
    n_cmp++; if (last_stuck !== 1'b1) begin n_bad++; $display("FAIL stuck0_flag got=%0b exp=1", last_stuck); end
    n_cmp++; if (last_cyc - prev_cyc !== 255) begin n_bad++; $display("FAIL stuck0_delay got=%0d exp=255", last_cyc - prev_cyc); end
    n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL stuck0_hold got=%0b exp=1", stuck); end
  endtask

  task automatic test_stuck_high();
    vbase = vcount;
    pwm(3, 8, 3);
    in = 1'b1;
    step(300);
    n_cmp++; if (vcount - vbase !== 4) begin n_bad++; $display("FAIL stuck1_count valids=%0d exp=4", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd0) begin n_bad++; $display("FAIL stuck1_period got=%0d exp=0", last_period); end
    n_cmp++; if (last_high !== 8'd255) begin n_bad++; $display("FAIL stuck1_high got=%0d exp=255", last_high); end
    n_cmp++; if (last_stuck !== 1'b1) begin n_bad++; $display("FAIL stuck1_flag got=%0b exp=1", last_stuck); end
    n_cmp++; if (last_cyc - prev_cyc !== 255) begin n_bad++; $display("FAIL stuck1_delay got=%0d exp=255", last_cyc - prev_cyc); end
  endtask

  task automatic test_resume();
    in = 1'b0;
    step(5);
    vbase = vcount;
    pwm(3, 8, 1);
    n_cmp++; if (vcount !== vbase) begin n_bad++; $display("FAIL resume_rearm valids=%0d exp=0", vcount - vbase); end
    n_cmp++; if (stuck !== 1'b1) begin n_bad++; $display("FAIL resume_stuck_kept got=%0b exp=1", stuck); end
    pwm(3, 8, 1);
    n_cmp++; if (vcount - vbase !== 1) begin n_bad++; $display("FAIL resume_count valids=%0d exp=1", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL resume_period got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd3) begin n_bad++; $display("FAIL resume_high got=%0d exp=3", last_high); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL resume_stuck got=%0b exp=0", stuck); end
  endtask

  task automatic test_enable();
    pwm(3, 8, 2);
    enable = 1'b0;
    vbase = vcount;
    pwm(3, 8, 2);
    n_cmp++; if (vcount !== vbase) begin n_bad++; $display("FAIL en_off_valids got=%0d exp=0", vcount - vbase); end
    n_cmp++; if (period !== 8'd11) begin n_bad++; $display("FAIL en_off_period got=%0d exp=11", period); end
    n_cmp++; if (high_time !== 8'd3) begin n_bad++; $display("FAIL en_off_high got=%0d exp=3", high_time); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL en_off_stuck got=%0b exp=0", stuck); end
    enable = 1'b1;
    pwm(3, 8, 1);
    n_cmp++; if (vcount !== vbase) begin n_bad++; $display("FAIL en_first_edge valids=%0d exp=0", vcount - vbase); end
    pwm(3, 8, 1);
    n_cmp++; if (vcount - vbase !== 1) begin n_bad++; $display("FAIL en_count valids=%0d exp=1", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL en_period got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd3) begin n_bad++; $display("FAIL en_high got=%0d exp=3", last_high); end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_p;
    logic [7:0] exp_h;
`ifdef REFLET_PWM_CAPTURE_GLITCH_FILTER_EN
    exp_p = 8'd15; exp_h = 8'd5;
`else
    exp_p = 8'd6;  exp_h = 8'd1;
`endif
    for (int r = 0; r < 4; r++) begin
      in = 1'b0; step(4);
      in = 1'b1; step(1);
      in = 1'b0; step(5);
      in = 1'b1; step(5);
    end
    in = 1'b0;
    step(3);
    n_cmp++; if (last_period !== exp_p) begin n_bad++; $display("FAIL glitch_period got=%0d exp=%0d", last_period, exp_p); end
    n_cmp++; if (last_high !== exp_h) begin n_bad++; $display("FAIL glitch_high got=%0d exp=%0d", last_high, exp_h); end
  endtask

  task automatic test_reset_mid();
    pwm(3, 8, 2);
    in = 1'b1;
    step(4);
    reset = 1'b0;
    #1;
    n_cmp++; if (period !== 8'd0) begin n_bad++; $display("FAIL rstmid_period got=%0d exp=0", period); end
    n_cmp++; if (high_time !== 8'd0) begin n_bad++; $display("FAIL rstmid_high got=%0d exp=0", high_time); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%0b exp=0", valid); end
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL rstmid_stuck got=%0b exp=0", stuck); end
    step(2);
    in = 1'b0;
    reset = 1'b1;
    step(2);
    vbase = vcount;
    pwm(3, 8, 1);
    n_cmp++; if (vcount !== vbase) begin n_bad++; $display("FAIL rstmid_first_edge valids=%0d exp=0", vcount - vbase); end
    pwm(3, 8, 1);
    n_cmp++; if (vcount - vbase !== 1) begin n_bad++; $display("FAIL rstmid_count valids=%0d exp=1", vcount - vbase); end
    n_cmp++; if (last_period !== 8'd11) begin n_bad++; $display("FAIL rstmid_period2 got=%0d exp=11", last_period); end
    n_cmp++; if (last_high !== 8'd3) begin n_bad++; $display("FAIL rstmid_high2 got=%0d exp=3", last_high); end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    in = 1'b0;
    test_reset();
    test_basic();
    test_pattern_change();
    test_stuck_low();
    test_stuck_high();
    test_resume();
    test_enable();
    test_glitch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
